img_loader: RTL
===============

IMG_LOADER -- requirements
Module: img_loader

Interface
REQ-001 SHALL have parameter NPIX, default 784, pixels per frame (28x28).
REQ-002 SHALL have parameter AW, default 10, pixel index/address width.
REQ-003 SHALL have port clk  in  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n  in  1  reset; asynchronous and active-low.
REQ-005 SHALL have port pix_valid  in  1  upstream pixel valid.
REQ-006 SHALL have port pix_ready  out  1  loader accepts a pixel this cycle.
REQ-007 SHALL have port pix_data  in  8  unsigned raw pixel, 0..255.
REQ-008 SHALL have port pix_last  in  1  marks the final pixel of a frame.
REQ-009 SHALL have port frame_valid  out  1  complete frame held, readable.
REQ-010 SHALL have port frame_release  in  1  one-cycle pulse; consumer is done with the frame.
REQ-011 SHALL have ports rd_addr0..rd_addr3  in  AW each  four pooling-window read addresses.
REQ-012 SHALL have ports rd_data0..rd_data3  out  8 signed each  pixel values for those addresses.
REQ-013 SHALL have port frame_err  out  1  sticky framing-error flag.
REQ-014 SHALL have port frame_cnt  out  16  count of frames completed, wraps.

Function
REQ-015 SHALL implement states LOAD, FULL and DRAIN.
REQ-016 Transfer SHALL occur only when pix_valid and pix_ready are both 1.
REQ-017 pix_ready SHALL be 1 in LOAD and in DRAIN, and 0 in FULL.
REQ-018 In LOAD, each transfer SHALL write pix_data>>1 (0..127, sign bit 0) at buffer index wr_cnt, then increment wr_cnt.
REQ-019 In LOAD, a transfer at wr_cnt==NPIX-1 with pix_last=1 SHALL:
  - enter FULL;
  - clear wr_cnt;
  - increment frame_cnt.
REQ-020 In LOAD, a transfer with pix_last=1 at wr_cnt<NPIX-1 (short frame) SHALL:
  - set frame_err;
  - clear wr_cnt;
  - stay in LOAD;
  - discard the frame.
REQ-021 In LOAD, a transfer at wr_cnt==NPIX-1 with pix_last=0 (long frame) SHALL:
  - set frame_err;
  - clear wr_cnt;
  - enter DRAIN.
REQ-022 DRAIN SHALL discard pixels, and SHALL return to LOAD the cycle after a transfer with pix_last=1.
REQ-023 frame_valid SHALL be 1 exactly while in FULL.
REQ-024 Buffer contents SHALL stay frozen while in FULL.
REQ-025 frame_release while in FULL SHALL cause LOAD on the next cycle.
REQ-026 frame_release in LOAD or DRAIN SHALL be ignored.
REQ-027 Each rd_dataN SHALL be registered, with 1-cycle latency from rd_addrN.
REQ-028 Reads SHALL be valid in every state.
REQ-029 An rd_addrN >= NPIX SHALL return 0.
REQ-030 frame_err SHALL stay set until reset.
REQ-031 frame_cnt SHALL wrap from 65535 to 0.
REQ-032 A read and a write to the same index in one cycle SHALL return the old value.

Reset
REQ-033 Asserting reset_n low SHALL immediately force:
  - state LOAD;
  - wr_cnt=0;
  - frame_valid=0;
  - pix_ready=0 while reset_n is low;
  - frame_err=0;
  - frame_cnt=0;
  - rd_data0..3=0.
REQ-034 Buffer contents SHALL NOT be reset.
REQ-035 pix_ready SHALL first be 1 on the first clk edge after reset_n is released.
REQ-036 Reset during LOAD, DRAIN or FULL SHALL abandon any partial or held frame.

Structure
REQ-037 NPIX, the row width 28 and the state enum SHALL live in the shared nn_pkg package.
REQ-038 Pixel storage SHALL be one sub-module, img_buffer_ram: NPIX x 8, one write port, four registered read ports.

Verification
REQ-039 The bench SHALL cover:
  - Frame load: stream 784 pixels, value = index mod 256, last on #783 -> frame_valid=1 the next cycle, pix_ready=0, frame_cnt=1; rd_addr0=300 -> rd_data0=22 one cycle later.
  - Short frame: last on pixel #99 -> frame_err=1, frame_valid stays 0; then a good frame -> frame_valid=1, frame_cnt=1.
  - Long frame: 784 pixels with no last, 5 more with last on the 5th -> frame_err=1, DRAIN; the next good frame loads correctly.
  - Release: frame_release pulse in FULL -> frame_valid=0 and pix_ready=1 the next cycle; second frame of 255s -> rd_data=127 everywhere.
  - Backpressure and bounds: pix_valid toggled randomly -> same buffer contents as a gapless stream; rd_addr=800 -> rd_data=0.
  - Mid-frame reset: reset_n low after 400 pixels -> all outputs 0 asynchronously; the full frame after release loads with frame_cnt=1.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared definitions for the image front end: frame geometry,
// loader state encoding and the raw-to-signed pixel scaling.
package nn_pkg;

    localparam int NPIX  = 784;
    localparam int ROW_W = 28;
    localparam int PIX_W = 8;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_FULL  = 2'd1,
        ST_DRAIN = 2'd2
    } ld_state_t;

    // Halving keeps the value in 0..127, so bit 7 (sign) is always 0.
    function automatic logic [PIX_W-1:0] pix_scale(
        input logic [PIX_W-1:0] raw
    );
        return {1'b0, raw[PIX_W-1:1]};
    endfunction

endpackage

// File: rtl/img_buffer_ram.sv
// Frame pixel store: NPIX x 8, one write port, four registered read ports.
// Ports: clk, reset_n (clears read registers only), we/wr_addr/wr_data,
// rd_addr[4] -> rd_data[4] one cycle later; out-of-range reads return 0.
module img_buffer_ram #(
    parameter int NPIX = 784,
    parameter int AW   = 10
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                we,
    input  logic [AW-1:0]       wr_addr,
    input  logic [7:0]          wr_data,
    input  logic [AW-1:0]       rd_addr [4],
    output logic signed [7:0]   rd_data [4]
);

    logic [7:0] mem [NPIX];

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Non-blocking read of mem gives old data on a same-index write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) begin
                rd_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (int'(rd_addr[i]) < NPIX) begin
                    rd_data[i] <= $signed(mem[rd_addr[i]]);
                end else begin
                    rd_data[i] <= '0;
                end
            end
        end
    end

endmodule

// File: rtl/img_loader.sv
// Streams one frame of raw pixels into a buffer and holds it for readout.
// Ports: pix_valid/pix_ready/pix_data/pix_last stream in, frame_valid,
// frame_release, rd_addr0..3 -> rd_data0..3, frame_err, frame_cnt.
module img_loader #(
    parameter int NPIX = nn_pkg::NPIX,
    parameter int AW   = 10
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                pix_valid,
    output logic                pix_ready,
    input  logic [7:0]          pix_data,
    input  logic                pix_last,
    output logic                frame_valid,
    input  logic                frame_release,
    input  logic [AW-1:0]       rd_addr0,
    input  logic [AW-1:0]       rd_addr1,
    input  logic [AW-1:0]       rd_addr2,
    input  logic [AW-1:0]       rd_addr3,
    output logic signed [7:0]   rd_data0,
    output logic signed [7:0]   rd_data1,
    output logic signed [7:0]   rd_data2,
    output logic signed [7:0]   rd_data3,
    output logic                frame_err,
    output logic [15:0]         frame_cnt
);

    import nn_pkg::*;

    ld_state_t        state;
    logic [AW-1:0]    wr_cnt;
    logic             xfer;
    logic             at_end;
    logic             we;
    logic [AW-1:0]    rd_addr [4];
    logic signed [7:0] rd_data [4];

    assign xfer   = pix_valid & pix_ready;
    assign at_end = (wr_cnt == AW'(NPIX - 1));
    assign we     = xfer && (state == ST_LOAD);

    assign rd_addr[0] = rd_addr0;
    assign rd_addr[1] = rd_addr1;
    assign rd_addr[2] = rd_addr2;
    assign rd_addr[3] = rd_addr3;
    assign rd_data0   = rd_data[0];
    assign rd_data1   = rd_data[1];
    assign rd_data2   = rd_data[2];
    assign rd_data3   = rd_data[3];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_LOAD;
            wr_cnt      <= '0;
            pix_ready   <= 1'b0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            unique case (state)
                ST_LOAD: begin
                    pix_ready   <= 1'b1;
                    frame_valid <= 1'b0;
                    if (xfer) begin
                        if (at_end) begin
                            wr_cnt <= '0;
                            if (pix_last) begin
                                state       <= ST_FULL;
                                pix_ready   <= 1'b0;
                                frame_valid <= 1'b1;
                                frame_cnt   <= frame_cnt + 16'd1;
                            end else begin
                                state     <= ST_DRAIN;
                                frame_err <= 1'b1;
                            end
                        end else if (pix_last) begin
                            // Short frame: drop it and restart at 0.
                            wr_cnt    <= '0;
                            frame_err <= 1'b1;
                        end else begin
                            wr_cnt <= wr_cnt + AW'(1);
                        end
                    end
                end
                ST_FULL: begin
                    if (frame_release) begin
                        state       <= ST_LOAD;
                        pix_ready   <= 1'b1;
                        frame_valid <= 1'b0;
                    end else begin
                        pix_ready   <= 1'b0;
                        frame_valid <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    pix_ready   <= 1'b1;
                    frame_valid <= 1'b0;
                    if (xfer && pix_last) begin
                        state <= ST_LOAD;
                    end
                end
                default: begin
                    state       <= ST_LOAD;
                    wr_cnt      <= '0;
                    pix_ready   <= 1'b1;
                    frame_valid <= 1'b0;
                end
            endcase
        end
    end

    img_buffer_ram #(
        .NPIX (NPIX),
        .AW   (AW)
    ) u_buf (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (we),
        .wr_addr (wr_cnt),
        .wr_data (pix_scale(pix_data)),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

endmodule
